fwd_hazard_unit: RTL
====================

# fwd_hazard_unit

Parametrised forwarding and hazard unit for the Core101 pipeline, sitting in the decode (ID) stage. It tracks the destination registers of in-flight instructions in an internal stage-tracker shift register and compares them against any number of ID source operands. It produces registered per-source forwarding selects and a combinational load-use stall. Youngest-producer priority, bubble insertion, flush and external hold are handled internally.

## Interface
- NUM_SRC, 2: number of source operands compared per ID instruction
- NUM_STAGES, 3: number of tracked stages after ID (index 0 = IS, youngest)
- ADDR_W, 5: register address width
- LATE_STAGE, 2: first tracker index from which a late (load) result is forwardable
- clock_in  input  1  clock, rising edge
- reset_in  input  1  asynchronous, active-high reset
- src_addr_in  input  NUM_SRC*ADDR_W  ID source addresses, source i at [i*ADDR_W +: ADDR_W]
- src_valid_in  input  NUM_SRC  per-source "operand is a register read" flag
- id_valid_in  input  1  ID holds a valid instruction
- dst_addr_in  input  ADDR_W  ID destination address
- dst_we_in  input  1  ID instruction writes dst_addr_in
- dst_late_in  input  1  ID result is available only from LATE_STAGE onward (load)
- hold_in  input  1  external pipeline freeze
- flush_in  input  1  squash all in-flight instructions
- fwd_sel_out  output  NUM_SRC*NUM_STAGES  registered one-hot select per source, source i at [i*NUM_STAGES +: NUM_STAGES]; bit k = forward from tracker k as seen at ID time; all-zero = register file
- stall_out  output  1  combinational load-use stall for ID
- stall_count_out  output  32  stall cycle counter (see Configuration)

## Operation
- Tracker k holds {valid, addr, late}. Entries with addr 0 are never written valid.
- Match for source i at tracker k: src_valid_in[i] and tracker k valid and addr equal to the source address and source address nonzero.
- Per source, the lowest matching k wins (youngest producer).
  - Select vector: one-hot at that k, or zero when there is no match.
- Hazard for source i: the winning tracker is late and k < LATE_STAGE.
- stall_out = id_valid_in and (OR of per-source hazards) and not flush_in.
- Advance (not hold_in):
  - Trackers shift k → k+1. The oldest entry drops out.
  - Tracker 0 loads {id_valid_in & dst_we_in & dst_addr_in≠0 & ~stall_out, dst_addr_in, dst_late_in}.
  - A stall inserts a bubble (valid 0).
  - fwd_sel_out captures the select vectors. It captures all-zero when stall_out or not id_valid_in.
- hold_in: trackers and fwd_sel_out keep their values. stall_out is still evaluated from current inputs.
- flush_in, which has priority over hold_in: all tracker valids clear and fwd_sel_out clears at the next edge.
- Simultaneous events:
  - flush beats hold, and hold beats advance.
  - A stall and a shift in the same cycle are normal: the producer moves one stage older, so the stall resolves after at most LATE_STAGE cycles.

## Timing
- Reset, asynchronous: all tracker valids 0, fwd_sel_out 0, stall_count_out 0. stall_out is therefore 0 while in reset.
- stall_out: zero-cycle combinational path from src_addr_in, src_valid_in, id_valid_in and flush_in.
- fwd_sel_out: 1-cycle latency. It is valid in the cycle the consumer occupies IS.
- Reset asserted mid-operation drops all in-flight state immediately. There is no recovery of pending writes.

## Configuration
- FWD_STALL_CNT_EN defined: stall_count_out increments by 1 on every clock edge where stall_out=1 and hold_in=0. It wraps at 2^32−1 → 0, and flush does not clear it.
- FWD_STALL_CNT_EN undefined: the counter is not instantiated and stall_count_out is tied to 0.

## Structure
- The shared package core101_pkg holds:
  - The tracker entry typedef {valid, addr, late}.
  - Default constants for NUM_STAGES, LATE_STAGE and ADDR_W.
- One sub-module, fwd_src_match: per-source comparator plus priority encoder. It takes one source address, its valid flag and the tracker array, and returns the one-hot select and the hazard bit. It is instantiated NUM_SRC times in a generate loop.

## Test plan
- Back-to-back dependency: issue x5 write, then x5 read on source 0 next cycle → fwd_sel_out source 0 = 3'b001 one cycle later, stall_out=0.
- Youngest priority: x7 written at trackers 0 and 2, source 1 reads x7 → source 1 select = 3'b001, never 3'b101.
- Load-use: load to x3 (late), next instruction reads x3 with LATE_STAGE=2 → stall_out=1 for 2 cycles, bubbles enter tracker 0, then select = 3'b100 and stall releases.
- x0 and invalid sources: write x0, then read x0; also src_valid_in=0 with a matching address → select all-zero, no stall.
- hold_in and flush_in: hold 3 cycles mid-dependency → trackers and fwd_sel_out frozen. Assert flush_in together with hold_in → all selects 0, and a following read of the previously pending register gets no forward.
- Counter, built with FWD_STALL_CNT_EN: 5 stall cycles, one of them under hold_in → stall_count_out=4. Built without the macro → stall_count_out stays 0.

Source files
------------

// File: rtl/core101_pkg.sv
// Shared Core101 definitions: tracker entry layout and default sizing
// for the forwarding/hazard unit.
package core101_pkg;

   localparam int DEF_NUM_STAGES = 3;
   localparam int DEF_LATE_STAGE = 2;
   localparam int DEF_ADDR_W     = 5;

   // One in-flight instruction as seen by the forwarding logic. The address
   // width is fixed here, so users of the entry must keep ADDR_W equal to
   // DEF_ADDR_W.
   typedef struct packed {
      logic                  valid;
      logic [DEF_ADDR_W-1:0] addr;
      logic                  late;
   } trk_entry_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage operand/destination bundle and forwarding results for
// fwd_hazard_unit. The master side drives ID information, and the slave side is
// the forwarding unit.
interface fwd_hazard_unit_if
   import core101_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int ADDR_W     = DEF_ADDR_W
);
   logic [NUM_SRC*ADDR_W-1:0]     src_addr_in;
   logic [NUM_SRC-1:0]            src_valid_in;
   logic                          id_valid_in;
   logic [ADDR_W-1:0]             dst_addr_in;
   logic                          dst_we_in;
   logic                          dst_late_in;
   logic                          hold_in;
   logic                          flush_in;
   logic [NUM_SRC*NUM_STAGES-1:0] fwd_sel_out;
   logic                          stall_out;
   logic [31:0]                   stall_count_out;

   modport master (
      output src_addr_in, src_valid_in, id_valid_in, dst_addr_in,
             dst_we_in, dst_late_in, hold_in, flush_in,
      input  fwd_sel_out, stall_out, stall_count_out
   );

   modport slave (
      input  src_addr_in, src_valid_in, id_valid_in, dst_addr_in,
             dst_we_in, dst_late_in, hold_in, flush_in,
      output fwd_sel_out, stall_out, stall_count_out
   );
endinterface

// File: rtl/fwd_src_match.sv
// Single-source comparator and priority encoder. It picks the youngest tracker
// that produces the source register and flags a load-use hazard when that
// producer's result is not forwardable yet.
module fwd_src_match
   import core101_pkg::*;
#(
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int LATE_STAGE = DEF_LATE_STAGE,
   parameter int ADDR_W     = DEF_ADDR_W
) (
   input  logic [ADDR_W-1:0]                 i_src_addr,
   input  logic                              i_src_valid,
   input  trk_entry_t [NUM_STAGES-1:0]       i_trk,
   output logic [NUM_STAGES-1:0]             o_sel,
   output logic                              o_hazard
);

   logic [NUM_STAGES-1:0] w_match;
   logic                  w_found;

   // raw per-tracker address match; x0 never forwards
   always_comb begin
      w_match = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         w_match[k] = i_src_valid && i_trk[k].valid &&
                      (i_trk[k].addr == i_src_addr) && (i_src_addr != '0);
      end
   end

   // lowest index wins: tracker 0 holds the youngest producer
   always_comb begin
      o_sel    = '0;
      o_hazard = 1'b0;
      w_found  = 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         if (w_match[k] && !w_found) begin
            o_sel[k] = 1'b1;
            o_hazard = i_trk[k].late && (k < LATE_STAGE);
            w_found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Core101 ID-stage forwarding and hazard unit. It shifts the destination of
// every issued instruction through a stage tracker. It also produces registered
// per-source forwarding selects and a combinational load-use stall.
// Optional feature macro: FWD_STALL_CNT_EN enables the stall-cycle counter.
module fwd_hazard_unit
   import core101_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int LATE_STAGE = DEF_LATE_STAGE
) (
   input logic              clock_in,
   input logic              reset_in,
   fwd_hazard_unit_if.slave bus
);

   trk_entry_t [NUM_STAGES-1:0]   r_trk;
   logic [NUM_SRC*NUM_STAGES-1:0] r_fwd_sel;
   logic [NUM_SRC*NUM_STAGES-1:0] w_sel;
   logic [NUM_SRC-1:0]            w_hazard;
   logic                          w_stall;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_match #(
         .NUM_STAGES (NUM_STAGES),
         .LATE_STAGE (LATE_STAGE),
         .ADDR_W     (ADDR_W)
      ) u_match (
         .i_src_addr  (bus.src_addr_in[i*ADDR_W +: ADDR_W]),
         .i_src_valid (bus.src_valid_in[i]),
         .i_trk       (r_trk),
         .o_sel       (w_sel[i*NUM_STAGES +: NUM_STAGES]),
         .o_hazard    (w_hazard[i])
      );
   end

   // A flush squashes whatever ID holds, so it can never request a stall.
   assign w_stall = bus.id_valid_in & (|w_hazard) & ~bus.flush_in;

   // tracker shift and select capture; flush beats hold, hold beats advance
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         r_trk     <= '0;
         r_fwd_sel <= '0;
      end else if (bus.flush_in) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            r_trk[k].valid <= 1'b0;
         end
         r_fwd_sel <= '0;
      end else if (!bus.hold_in) begin
         r_trk[0].valid <= bus.id_valid_in & bus.dst_we_in &
                           (bus.dst_addr_in != '0) & ~w_stall;
         r_trk[0].addr  <= bus.dst_addr_in;
         r_trk[0].late  <= bus.dst_late_in;
         for (int k = 1; k < NUM_STAGES; k++) begin
            r_trk[k] <= r_trk[k-1];
         end
         r_fwd_sel <= (w_stall || !bus.id_valid_in) ? '0 : w_sel;
      end
   end

   assign bus.fwd_sel_out = r_fwd_sel;
   assign bus.stall_out   = w_stall;

`ifdef FWD_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   // count stall cycles that actually cost a pipeline slot; wraps naturally
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         r_stall_cnt <= '0;
      end else if (w_stall && !bus.hold_in) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign bus.stall_count_out = r_stall_cnt;
`else
   assign bus.stall_count_out = '0;
`endif

endmodule
